// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register. It detects load-use hazards and inserts a bubble when forwarding
// cannot cover the dependency. It squashes on flush, freezes on a memory stall and counts
// load-use stall cycles.
module id_ex_hazard_stage #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMM_WIDTH   = 16,
    parameter int ALU_OP_W    = 4,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   IF_ID_valid,
    input  logic [2:0]             IF_ID_RegS1,
    input  logic [2:0]             IF_ID_RegS2,
    input  logic [2:0]             IF_ID_RegD,
    input  logic                   ID_uses_rs1,
    input  logic                   ID_uses_rs2,
    input  logic                   ID_wb_enabled,
    input  logic                   ID_MemRead,
    input  logic                   ID_MemWrite,
    input  logic [ALU_OP_W-1:0]    ID_alu_op,
    input  logic [DATA_WIDTH-1:0]  ID_rs1_data,
    input  logic [DATA_WIDTH-1:0]  ID_rs2_data,
    input  logic [IMM_WIDTH-1:0]   ID_imm,
    input  logic                   flush_ex,
    input  logic                   mem_stall,
    input  logic                   stall_cnt_clr,
    output logic                   ID_EX_valid,
    output logic [2:0]             ID_EX_RegS1,
    output logic [2:0]             ID_EX_RegS2,
    output logic [2:0]             ID_EX_RegD,
    output logic                   ID_EX_wb_enabled,
    output logic                   ID_EX_MemRead,
    output logic                   ID_EX_MemWrite,
    output logic [ALU_OP_W-1:0]    ID_EX_alu_op,
    output logic [DATA_WIDTH-1:0]  ID_EX_rs1_data,
    output logic [DATA_WIDTH-1:0]  ID_EX_rs2_data,
    output logic [IMM_WIDTH-1:0]   ID_EX_imm,
    output logic                   stall_if_id,
    output logic [STALL_CNT_W-1:0] load_use_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [2:0]            rs1;
        logic [2:0]            rs2;
        logic [2:0]            rd;
        logic                  wb;
        logic                  mrd;
        logic                  mwr;
        logic [ALU_OP_W-1:0]   alu;
        logic [DATA_WIDTH-1:0] d1;
        logic [DATA_WIDTH-1:0] d2;
        logic [IMM_WIDTH-1:0]  imm;
    } idex_t;

    idex_t                  ex_q, ex_d, id_in;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   lu, dep1, dep2, hazard, stall;

    always_comb begin
        id_in       = '0;
        id_in.valid = IF_ID_valid;
        id_in.rs1   = IF_ID_RegS1;
        id_in.rs2   = IF_ID_RegS2;
        id_in.rd    = IF_ID_RegD;
        id_in.wb    = ID_wb_enabled;
        id_in.mrd   = ID_MemRead;
        id_in.mwr   = ID_MemWrite;
        id_in.alu   = ID_alu_op;
        id_in.d1    = ID_rs1_data;
        id_in.d2    = ID_rs2_data;
        id_in.imm   = ID_imm;
    end

    // Store data (rs2 of a store) is forwarded load->store in MEM, so it never stalls.
    assign lu     = ex_q.valid & ex_q.mrd & ex_q.wb & IF_ID_valid;
    assign dep1   = ID_uses_rs1 & (IF_ID_RegS1 == ex_q.rd);
    assign dep2   = ID_uses_rs2 & (IF_ID_RegS2 == ex_q.rd) & ~ID_MemWrite;
    assign hazard = lu & (dep1 | dep2);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        stall = 1'b0;
        if (flush_ex) begin
            ex_d = '0;
        end else if (mem_stall) begin
            stall = 1'b1;
        end else if (hazard) begin
            ex_d  = '0;
            stall = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + STALL_CNT_W'(1);
        end else begin
            ex_d = id_in;
        end
        if (stall_cnt_clr) cnt_d = '0;
    end

    // Hold decode low during reset, even if mem_stall is asserted upstream.
    assign stall_if_id = stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ID_EX_valid      = ex_q.valid;
    assign ID_EX_RegS1      = ex_q.rs1;
    assign ID_EX_RegS2      = ex_q.rs2;
    assign ID_EX_RegD       = ex_q.rd;
    assign ID_EX_wb_enabled = ex_q.wb;
    assign ID_EX_MemRead    = ex_q.mrd;
    assign ID_EX_MemWrite   = ex_q.mwr;
    assign ID_EX_alu_op     = ex_q.alu;
    assign ID_EX_rs1_data   = ex_q.d1;
    assign ID_EX_rs2_data   = ex_q.d2;
    assign ID_EX_imm        = ex_q.imm;
    assign load_use_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed load-use scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IF_ID_valid = 0;
    logic [2:0]  IF_ID_RegS1 = 0, IF_ID_RegS2 = 0, IF_ID_RegD = 0;
    logic        ID_uses_rs1 = 0, ID_uses_rs2 = 0, ID_wb_enabled = 0;
    logic        ID_MemRead = 0, ID_MemWrite = 0;
    logic [3:0]  ID_alu_op = 0;
    logic [15:0] ID_rs1_data = 0, ID_rs2_data = 0, ID_imm = 0;
    logic        flush_ex = 0, mem_stall = 0, stall_cnt_clr = 0;
    logic        ID_EX_valid, ID_EX_wb_enabled, ID_EX_MemRead, ID_EX_MemWrite;
    logic [2:0]  ID_EX_RegS1, ID_EX_RegS2, ID_EX_RegD;
    logic [3:0]  ID_EX_alu_op;
    logic [15:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic        stall_if_id;
    logic [7:0]  load_use_cnt;

    id_ex_hazard_stage dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_valid(IF_ID_valid), .IF_ID_RegS1(IF_ID_RegS1), .IF_ID_RegS2(IF_ID_RegS2),
        .IF_ID_RegD(IF_ID_RegD), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_wb_enabled(ID_wb_enabled), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_alu_op(ID_alu_op), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data),
        .ID_imm(ID_imm), .flush_ex(flush_ex), .mem_stall(mem_stall),
        .stall_cnt_clr(stall_cnt_clr),
        .ID_EX_valid(ID_EX_valid), .ID_EX_RegS1(ID_EX_RegS1), .ID_EX_RegS2(ID_EX_RegS2),
        .ID_EX_RegD(ID_EX_RegD), .ID_EX_wb_enabled(ID_EX_wb_enabled),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_rs1_data(ID_EX_rs1_data),
        .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
        .stall_if_id(stall_if_id), .load_use_cnt(load_use_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the architectural contents of the EX slot, plus the stall count.
    typedef struct packed {
        bit v; bit [2:0] s1, s2, d; bit wb, mr, mw; bit [3:0] alu; bit [15:0] r1, r2, imm;
    } slot_t;
    slot_t m_slot;
    int    m_cnt;

    function automatic bit m_hazard();
        bit load_in_ex;
        bit waits_rs1, waits_rs2;
        load_in_ex = m_slot.v && m_slot.mr && m_slot.wb && IF_ID_valid;
        waits_rs1  = ID_uses_rs1 && (IF_ID_RegS1 == m_slot.d);
        waits_rs2  = ID_uses_rs2 && (IF_ID_RegS2 == m_slot.d) && !ID_MemWrite;
        return load_in_ex && (waits_rs1 || waits_rs2);
    endfunction

    function automatic slot_t decode_slot();
        slot_t s;
        s = '{IF_ID_valid, IF_ID_RegS1, IF_ID_RegS2, IF_ID_RegD, ID_wb_enabled, ID_MemRead,
              ID_MemWrite, ID_alu_op, ID_rs1_data, ID_rs2_data, ID_imm};
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot = '0;
            m_cnt  = 0;
        end else begin
            bit hz;
            hz = m_hazard();
            if (stall_cnt_clr) m_cnt = 0;
            else if (!flush_ex && !mem_stall && hz) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (flush_ex || (!mem_stall && hz)) m_slot = '0;
            else if (!mem_stall) m_slot = decode_slot();
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        slot_t dut_slot;
        bit    exp_stall;
        dut_slot = '{ID_EX_valid, ID_EX_RegS1, ID_EX_RegS2, ID_EX_RegD, ID_EX_wb_enabled,
                     ID_EX_MemRead, ID_EX_MemWrite, ID_EX_alu_op, ID_EX_rs1_data,
                     ID_EX_rs2_data, ID_EX_imm};
        exp_stall = rst_n && !flush_ex && (mem_stall || m_hazard());
        chk("model_slot", 64'(dut_slot), 64'(m_slot));
        chk("model_stall", 64'(stall_if_id), 64'(exp_stall));
        chk("model_cnt", 64'(load_use_cnt), 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input bit v, input bit [2:0] s1, input bit [2:0] s2, input bit [2:0] d,
                         input bit u1, input bit u2, input bit wb, input bit mr, input bit mw);
        IF_ID_valid = v; IF_ID_RegS1 = s1; IF_ID_RegS2 = s2; IF_ID_RegD = d;
        ID_uses_rs1 = u1; ID_uses_rs2 = u2; ID_wb_enabled = wb;
        ID_MemRead = mr; ID_MemWrite = mw;
        ID_alu_op = 4'($urandom); ID_rs1_data = 16'($urandom);
        ID_rs2_data = 16'($urandom); ID_imm = 16'($urandom);
    endtask

    // lw r3 : valid, rd=3, writes back, loads
    task automatic lw_r3();
        instr(1, 0, 0, 3, 1, 0, 1, 1, 0);
    endtask

    initial begin
        int c0;
        #12 rst_n = 1'b1;
        step();
        chk("reset_cnt", 64'(load_use_cnt), 0);

        // lw r3 ; add r1,r3,r2
        lw_r3(); step();
        instr(1, 3, 2, 1, 1, 1, 1, 0, 0); #1;
        chk("lu_stall", 64'(stall_if_id), 1);
        step();
        chk("lu_bubble_valid", 64'(ID_EX_valid), 0);
        chk("lu_cnt", 64'(load_use_cnt), 1);
        chk("lu_selfclear", 64'(stall_if_id), 0);
        step();
        chk("lu_add_valid", 64'(ID_EX_valid), 1);
        chk("lu_add_rs1", 64'(ID_EX_RegS1), 3);

        // lw r3 ; sw data=r3 (no stall) then lw r3 ; sw addr=r3 (stall)
        lw_r3(); step();
        instr(1, 2, 3, 0, 1, 1, 0, 0, 1); #1;
        chk("sw_data_nostall", 64'(stall_if_id), 0);
        step();
        chk("sw_enters", 64'({ID_EX_valid, ID_EX_MemWrite}), 64'b11);
        lw_r3(); step();
        instr(1, 3, 2, 0, 1, 1, 0, 0, 1); #1;
        chk("sw_addr_stall", 64'(stall_if_id), 1);
        step(); step();

        // hazard with flush in same cycle
        c0 = int'(load_use_cnt);
        lw_r3(); step();
        instr(1, 3, 2, 1, 1, 1, 1, 0, 0); flush_ex = 1; #1;
        chk("flush_nostall", 64'(stall_if_id), 0);
        step();
        flush_ex = 0;
        chk("flush_bubble", 64'(ID_EX_valid), 0);
        chk("flush_cnt", 64'(load_use_cnt), 64'(c0));

        // hazard held under mem_stall for 3 cycles
        lw_r3(); step();
        c0 = int'(load_use_cnt);
        instr(1, 3, 2, 1, 1, 1, 1, 0, 0); mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mstall_hold", 64'({ID_EX_valid, ID_EX_MemRead, ID_EX_RegD}), 64'b1_1_011);
            chk("mstall_cnt", 64'(load_use_cnt), 64'(c0));
        end
        mem_stall = 0; #1;
        chk("mstall_release_stall", 64'(stall_if_id), 1);
        step();
        chk("mstall_bubble", 64'(ID_EX_valid), 0);
        chk("mstall_cnt_inc", 64'(load_use_cnt), 64'(c0 + 1));
        step();

        // saturation over 256 load-use pairs, then clear winning over an increment
        for (int i = 0; i < 256; i++) begin
            lw_r3(); step();
            instr(1, 3, 2, 1, 1, 1, 1, 0, 0); step(); step();
        end
        chk("sat_255", 64'(load_use_cnt), 255);
        lw_r3(); step();
        instr(1, 3, 2, 1, 1, 1, 1, 0, 0); stall_cnt_clr = 1; step();
        stall_cnt_clr = 0;
        chk("clr_wins", 64'(load_use_cnt), 0);

        // randomized traffic, with an asynchronous reset dropped in mid-stream
        for (int i = 0; i < 3000; i++) begin
            instr($urandom_range(0, 9) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            flush_ex      = $urandom_range(0, 9) == 0;
            mem_stall     = $urandom_range(0, 6) == 0;
            stall_cnt_clr = $urandom_range(0, 40) == 0;
            if (i == 1500) begin
                mem_stall = 1;
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_slot", 64'({ID_EX_valid, ID_EX_RegD, ID_EX_MemRead, ID_EX_rs1_data,
                                           ID_EX_imm}), 0);
                chk("async_rst_stall", 64'(stall_if_id), 0);
                chk("async_rst_cnt", 64'(load_use_cnt), 0);
                step();
                #1 rst_n = 1'b1;
            end
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
